// File: rtl/jtag_blaster_engine.sv
// ---------------------------------------------------------------------------
// jtag_blaster_engine
//
// Byte-command interpreter for the USB-Blaster family. Command bytes are
// pulled from an RX FIFO and turned into JTAG / Active-Serial pin activity.
// Sampled TDO/ASDO data is returned to the host through a TX FIFO.
//
// Command byte decoding (when no shift count is pending):
//   bit7 = 0 : bit-bang byte. It drives TCK=b0, TMS=b1, nCE=b2, nCS=b3,
//              TDI=b4 and OE=b5. If b6=1, one readback byte is returned.
//   bit7 = 1 : header byte. b[5:0] gives the number of following bytes to
//              shift out LSB first. b6 requests a readback byte for each
//              shifted byte.
//
// Parameters
//   TCK_HALF   TCK high time and low time in CLK cycles (2..255).
//   RX_RD_LAT  RX FIFO read latency: 0 = show-ahead, 1 = normal FIFO.
//
// Compile-time option
//   JTAG_ENGINE_AS_MODE_EN  When defined, Active-Serial support is built in.
//                           When undefined, B_NCE/B_NCS are tied high, the
//                           shift carry always comes from B_TDO and B_ASDO
//                           is ignored.
//
// Ports
//   CLK        in   single clock, rising edge
//   nRST       in   synchronous active-low reset
//   B_TDO      in   JTAG TDO
//   B_ASDO     in   Active-Serial data out
//   B_TCK      out  JTAG TCK
//   B_TMS      out  JTAG TMS
//   B_TDI      out  JTAG TDI
//   B_NCE      out  Active-Serial nCE
//   B_NCS      out  Active-Serial nCS
//   B_OE       out  LED / output enable
//   RX_EMPTY   in   RX FIFO empty
//   RX_RD_REQ  out  RX FIFO read strobe, one cycle per byte
//   D_IN       in   RX FIFO data
//   TX_FULL    in   TX FIFO full
//   TX_WR_REQ  out  TX FIFO write strobe, one cycle per byte
//   D_OUT      out  TX FIFO data, valid while TX_WR_REQ is high
//   BUSY       out  engine active or shift bytes still pending
// ---------------------------------------------------------------------------
module jtag_blaster_engine #(
    parameter int TCK_HALF  = 2,
    parameter int RX_RD_LAT = 1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       B_TDO,
    input  logic       B_ASDO,
    output logic       B_TCK,
    output logic       B_TMS,
    output logic       B_TDI,
    output logic       B_NCE,
    output logic       B_NCS,
    output logic       B_OE,
    input  logic       RX_EMPTY,
    output logic       RX_RD_REQ,
    input  logic [7:0] D_IN,
    input  logic       TX_FULL,
    output logic       TX_WR_REQ,
    output logic [7:0] D_OUT,
    output logic       BUSY
);

    typedef enum logic [3:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        PARSE,
        BITS,
        HDR,
        BIT_SETUP,
        TCK_HI,
        TCK_LO,
        TX_WAIT,
        TX_WR
    } state_t;

    // Phase counter load values. TCK_HI counts down from TCK_HALF-1, so the
    // first high cycle is recognised by the counter still holding its load
    // value. TCK_LO lasts one cycle less, because BIT_SETUP supplies the
    // remaining low cycle of the bit period.
    localparam logic [7:0] PH_HI_FIRST = 8'(TCK_HALF - 1);
    localparam logic [7:0] PH_LO_START = 8'(TCK_HALF - 2);
    localparam logic       SHOW_AHEAD  = (RX_RD_LAT == 0);

    state_t      state;
    state_t      next_state;

    logic [7:0]  shifter;
    logic [5:0]  byte_cnt;
    logic        rd_flag;
    logic [2:0]  bit_idx;
    logic [7:0]  phase;
    logic        carry;

    logic        carry_in;
    logic [7:0]  readback;

`ifdef JTAG_ENGINE_AS_MODE_EN
    // With nCS deasserted the JTAG chain is being shifted; otherwise the
    // serial flash is selected and its data comes back on ASDO.
    assign carry_in = B_NCS ? B_TDO : B_ASDO;
    assign readback = {6'b0, B_ASDO, B_TDO};
`else
    logic unused_asdo;

    assign carry_in    = B_TDO;
    assign readback    = {7'b0, B_TDO};
    assign unused_asdo = B_ASDO;
    assign B_NCE       = 1'b1;
    assign B_NCS       = 1'b1;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and FIFO strobes
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        RX_RD_REQ  = 1'b0;
        TX_WR_REQ  = 1'b0;
        D_OUT      = 8'h00;

        case (state)
            IDLE: begin
                if (!RX_EMPTY) begin
                    next_state = RD_REQ;
                end
            end

            RD_REQ: begin
                RX_RD_REQ  = 1'b1;
                next_state = SHOW_AHEAD ? PARSE : RD_WAIT;
            end

            RD_WAIT: begin
                next_state = PARSE;
            end

            PARSE: begin
                if (byte_cnt != 6'd0) begin
                    next_state = BIT_SETUP;
                end else if (shifter[7]) begin
                    next_state = HDR;
                end else begin
                    next_state = BITS;
                end
            end

            BITS: begin
                next_state = shifter[6] ? TX_WAIT : IDLE;
            end

            HDR: begin
                next_state = IDLE;
            end

            BIT_SETUP: begin
                next_state = TCK_HI;
            end

            TCK_HI: begin
                if (phase == 8'd0) begin
                    next_state = TCK_LO;
                end
            end

            TCK_LO: begin
                if (phase == 8'd0) begin
                    if (bit_idx == 3'd7) begin
                        next_state = rd_flag ? TX_WAIT : IDLE;
                    end else begin
                        next_state = BIT_SETUP;
                    end
                end
            end

            TX_WAIT: begin
                if (!TX_FULL) begin
                    next_state = TX_WR;
                end
            end

            TX_WR: begin
                TX_WR_REQ  = 1'b1;
                D_OUT      = shifter;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign BUSY = (state != IDLE) || (byte_cnt != 6'd0);

    // ------------------------------------------------------------------
    // Pins, byte count and read flag (reset-controlled)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            B_TCK    <= 1'b0;
            B_TMS    <= 1'b0;
            B_TDI    <= 1'b0;
            B_OE     <= 1'b0;
`ifdef JTAG_ENGINE_AS_MODE_EN
            B_NCE    <= 1'b1;
            B_NCS    <= 1'b1;
`endif
            byte_cnt <= 6'd0;
            rd_flag  <= 1'b0;
        end else begin
            case (state)
                PARSE: begin
                    // First data bit goes out together with TCK low, so
                    // TDO is already valid when BIT_SETUP samples it.
                    if (byte_cnt != 6'd0) begin
                        B_TCK <= 1'b0;
                        B_TDI <= shifter[0];
                    end
                end

                BITS: begin
                    B_TCK <= shifter[0];
                    B_TMS <= shifter[1];
`ifdef JTAG_ENGINE_AS_MODE_EN
                    B_NCE <= shifter[2];
                    B_NCS <= shifter[3];
`endif
                    B_TDI <= shifter[4];
                    B_OE  <= shifter[5];
                end

                HDR: begin
                    byte_cnt <= shifter[5:0];
                    rd_flag  <= shifter[6];
                end

                BIT_SETUP: begin
                    B_TDI <= shifter[0];
                    B_TCK <= 1'b1;
                end

                TCK_HI: begin
                    // Falling edge of TCK: present the next bit right away
                    // so it is stable for the whole low half-period.
                    if (phase == 8'd0) begin
                        B_TCK <= 1'b0;
                        if (bit_idx != 3'd7) begin
                            B_TDI <= shifter[0];
                        end
                    end
                end

                TCK_LO: begin
                    if ((phase == 8'd0) && (bit_idx == 3'd7) && (byte_cnt != 6'd0)) begin
                        byte_cnt <= byte_cnt - 6'd1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shifter, carry, bit index and phase counter (data path, no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        case (state)
            RD_REQ: begin
                if (SHOW_AHEAD) begin
                    shifter <= D_IN;
                end
            end

            RD_WAIT: begin
                shifter <= D_IN;
            end

            PARSE: begin
                bit_idx <= 3'd0;
            end

            BITS: begin
                shifter <= readback;
            end

            BIT_SETUP: begin
                carry <= carry_in;
                phase <= PH_HI_FIRST;
            end

            TCK_HI: begin
                if (phase == PH_HI_FIRST) begin
                    shifter <= {carry, shifter[7:1]};
                end
                if (phase == 8'd0) begin
                    phase <= PH_LO_START;
                end else begin
                    phase <= phase - 8'd1;
                end
            end

            TCK_LO: begin
                if (phase == 8'd0) begin
                    if (bit_idx != 3'd7) begin
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    phase <= phase - 8'd1;
                end
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_jtag_blaster_engine.sv
module tb_jtag_blaster_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance A: TCK_HALF=2, RX_RD_LAT=1 ----------------
    logic       tdo_a, asdo_a, loop_a, tdo_pin_a;
    logic       tck_a, tms_a, tdi_a, nce_a, ncs_a, oe_a;
    logic       rx_empty_a, rd_req_a, tx_full_a, wr_req_a, busy_a;
    logic [7:0] din_a = 8'h00;
    logic [7:0] dout_a;
    logic [7:0] mem_a [64];
    int         wr_a = 0;
    int         rd_a = 0;

    assign tdo_pin_a  = loop_a ? tdi_a : tdo_a;
    assign rx_empty_a = (wr_a == rd_a);

    // normal FIFO: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (rd_req_a) begin
            din_a <= mem_a[rd_a];
            rd_a  <= rd_a + 1;
        end
    end

    jtag_blaster_engine #(.TCK_HALF(2), .RX_RD_LAT(1)) u_dut (
        .CLK(clk), .nRST(nrst), .B_TDO(tdo_pin_a), .B_ASDO(asdo_a),
        .B_TCK(tck_a), .B_TMS(tms_a), .B_TDI(tdi_a), .B_NCE(nce_a),
        .B_NCS(ncs_a), .B_OE(oe_a), .RX_EMPTY(rx_empty_a), .RX_RD_REQ(rd_req_a),
        .D_IN(din_a), .TX_FULL(tx_full_a), .TX_WR_REQ(wr_req_a), .D_OUT(dout_a),
        .BUSY(busy_a)
    );

    // ---------------- instance B: TCK_HALF=5, RX_RD_LAT=0 ----------------
    logic       tdo_b, asdo_b;
    logic       tck_b, tms_b, tdi_b, nce_b, ncs_b, oe_b;
    logic       rx_empty_b, rd_req_b, tx_full_b, wr_req_b, busy_b;
    logic [7:0] din_b;
    logic [7:0] dout_b;
    logic [7:0] mem_b [64];
    int         wr_b = 0;
    int         rd_b = 0;

    assign rx_empty_b = (wr_b == rd_b);
    assign din_b      = mem_b[rd_b];   // show-ahead head of queue

    always @(posedge clk) begin
        if (rd_req_b) begin
            rd_b <= rd_b + 1;
        end
    end

    jtag_blaster_engine #(.TCK_HALF(5), .RX_RD_LAT(0)) u_dut_sa (
        .CLK(clk), .nRST(nrst), .B_TDO(tdo_b), .B_ASDO(asdo_b),
        .B_TCK(tck_b), .B_TMS(tms_b), .B_TDI(tdi_b), .B_NCE(nce_b),
        .B_NCS(ncs_b), .B_OE(oe_b), .RX_EMPTY(rx_empty_b), .RX_RD_REQ(rd_req_b),
        .D_IN(din_b), .TX_FULL(tx_full_b), .TX_WR_REQ(wr_req_b), .D_OUT(dout_b),
        .BUSY(busy_b)
    );

    // ---------------- monitors (sampled on the falling edge) ----------------
    int         cyc        = 0;
    int         tx_cnt_a   = 0;
    logic [7:0] tx_last_a  = 8'h00;
    logic       tck_prev_a = 1'b0;
    logic       tdi_prev_a = 1'b0;
    logic [7:0] tdi_seq_a  = 8'h00;
    int         tdi_viol_a = 0;
    int         rd_empty_a = 0;
    int         rise_cyc_a [$];

    int         tx_cnt_b   = 0;
    logic       tck_prev_b = 1'b0;
    int         hi_run_b   = 0;
    int         rd_empty_b = 0;
    int         rise_cyc_b [$];
    int         hi_w_b [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr_req_a) begin
            tx_cnt_a  <= tx_cnt_a + 1;
            tx_last_a <= dout_a;
        end
        if (tck_a && !tck_prev_a) begin
            rise_cyc_a.push_back(cyc);
            tdi_seq_a <= {tdi_a, tdi_seq_a[7:1]};
        end
        if (tck_a && tck_prev_a && (tdi_a != tdi_prev_a)) begin
            tdi_viol_a <= tdi_viol_a + 1;
        end
        if (rd_req_a && rx_empty_a) begin
            rd_empty_a <= rd_empty_a + 1;
        end
        tck_prev_a <= tck_a;
        tdi_prev_a <= tdi_a;

        if (wr_req_b) begin
            tx_cnt_b <= tx_cnt_b + 1;
        end
        if (tck_b && !tck_prev_b) begin
            rise_cyc_b.push_back(cyc);
        end
        if (tck_b) begin
            hi_run_b <= hi_run_b + 1;
        end else if (tck_prev_b) begin
            hi_w_b.push_back(hi_run_b);
            hi_run_b <= 0;
        end
        if (rd_req_b && rx_empty_b) begin
            rd_empty_b <= rd_empty_b + 1;
        end
        tck_prev_b <= tck_b;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] b);
        mem_a[wr_a] = b;
        wr_a++;
    endtask

    task automatic push_b(input logic [7:0] b);
        mem_b[wr_b] = b;
        wr_b++;
    endtask

    task automatic wait_idle_a(input string tag, input int bound);
        int k;
        k = 0;
        while (busy_a && (k < bound)) begin
            step(1);
            k++;
        end
        chk({tag, "_idle"}, 32'(busy_a), 32'd0);
    endtask

    task automatic wait_idle_b(input string tag, input int bound);
        int k;
        k = 0;
        while (busy_b && (k < bound)) begin
            step(1);
            k++;
        end
        chk({tag, "_idle"}, 32'(busy_b), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int r0, t0, hi, w, bad;

        nrst      = 1'b0;
        tdo_a     = 1'b0;
        asdo_a    = 1'b0;
        loop_a    = 1'b0;
        tx_full_a = 1'b0;
        tdo_b     = 1'b0;
        asdo_b    = 1'b0;
        tx_full_b = 1'b0;
        step(3);

        chk("rst_pins_a", 32'({tck_a, tms_a, tdi_a, nce_a, ncs_a, oe_a}), 32'b000110);
        chk("rst_ctl_a", 32'({rd_req_a, wr_req_a, busy_a}), 32'd0);
        chk("rst_dout_a", 32'(dout_a), 32'h00);
        chk("rst_pins_b", 32'({tck_b, tms_b, tdi_b, nce_b, ncs_b, oe_b}), 32'b000110);
        chk("rst_ctl_b", 32'({rd_req_b, wr_req_b, busy_b}), 32'd0);
        nrst = 1'b1;
        step(2);
        chk("idle_empty_busy", 32'(busy_a), 32'd0);

        // ---- bit-bang 0x5B with readback, TDO=1 ASDO=0 ----
        tdo_a = 1'b1;
        asdo_a = 1'b0;
        t0 = tx_cnt_a;
        push_a(8'h5B);
        step(4);
        chk("bb_tms_before", 32'(tms_a), 32'd0);
        step(1);
        chk("bb_tms_latency", 32'(tms_a), 32'd1);
        wait_idle_a("bb", 50);
        chk("bb_pins", 32'({tck_a, tms_a, tdi_a, oe_a}), 32'b1110);
`ifdef JTAG_ENGINE_AS_MODE_EN
        chk("bb_nce_ncs", 32'({nce_a, ncs_a}), 32'b01);
`else
        chk("bb_nce_ncs", 32'({nce_a, ncs_a}), 32'b11);
`endif
        chk("bb_tx_count", 32'(tx_cnt_a - t0), 32'd1);
        chk("bb_tx_data", 32'(tx_last_a), 32'h01);

        // ---- shift with read: 0xC1 then 0xA5, TDO looped from TDI ----
        loop_a = 1'b1;
        r0 = rise_cyc_a.size();
        t0 = tx_cnt_a;
        push_a(8'hC1);
        push_a(8'hA5);
        step(2);
        wait_idle_a("sh", 300);
        chk("sh_rises", 32'(rise_cyc_a.size() - r0), 32'd8);
        chk("sh_tdi_seq", 32'(tdi_seq_a), 32'hA5);
        bad = 0;
        if (rise_cyc_a.size() >= r0 + 8) begin
            for (int i = 1; i < 8; i++) begin
                if (rise_cyc_a[r0 + i] - rise_cyc_a[r0 + i - 1] != 4) bad++;
            end
        end
        chk("sh_bit_period", 32'(bad), 32'd0);
        chk("sh_tx_count", 32'(tx_cnt_a - t0), 32'd1);
        chk("sh_tx_data", 32'(tx_last_a), 32'hA5);
        chk("sh_tck_low", 32'(tck_a), 32'd0);

        // ---- TX back-pressure ----
        tx_full_a = 1'b1;
        t0 = tx_cnt_a;
        push_a(8'hC1);
        push_a(8'hA5);
        step(45);
        hi = 0;
        w = 0;
        for (int i = 0; i < 10; i++) begin
            if (tck_a) hi++;
            if (wr_req_a) w++;
            step(1);
        end
        chk("bp_tck_held_low", 32'(hi), 32'd0);
        chk("bp_no_write", 32'(w + tx_cnt_a - t0), 32'd0);
        chk("bp_busy", 32'(busy_a), 32'd1);
        tx_full_a = 1'b0;
        step(1);
        chk("bp_wr_next_cycle", 32'(wr_req_a), 32'd1);
        chk("bp_wr_data", 32'(dout_a), 32'hA5);
        step(1);
        chk("bp_single_pulse", 32'({wr_req_a, busy_a}), 32'd0);

        // ---- reset mid-shift ----
        push_a(8'hC1);
        push_a(8'hA5);
        step(20);
        t0 = tx_cnt_a;
        nrst = 1'b0;
        step(3);
        chk("mid_rst_pins", 32'({tck_a, tms_a, tdi_a, nce_a, ncs_a, oe_a}), 32'b000110);
        chk("mid_rst_ctl", 32'({rd_req_a, wr_req_a, busy_a}), 32'd0);
        chk("mid_rst_dout", 32'(dout_a), 32'h00);
        nrst = 1'b1;
        step(50);
        chk("mid_rst_no_tx", 32'(tx_cnt_a - t0), 32'd0);
        chk("mid_rst_idle", 32'({busy_a, tck_a}), 32'd0);

        // ---- bit-bang readback with ASDO=1, TDO=0 ----
        loop_a = 1'b0;
        tdo_a = 1'b0;
        asdo_a = 1'b1;
        t0 = tx_cnt_a;
        push_a(8'h40);
        step(2);
        wait_idle_a("as", 50);
        chk("as_tx_count", 32'(tx_cnt_a - t0), 32'd1);
`ifdef JTAG_ENGINE_AS_MODE_EN
        chk("as_tx_data", 32'(tx_last_a), 32'h02);
        chk("as_ncs", 32'(ncs_a), 32'd0);
`else
        chk("as_tx_data", 32'(tx_last_a), 32'h00);
        chk("as_ncs", 32'(ncs_a), 32'd1);
`endif

        // ---- show-ahead, TCK_HALF=5: header 0x82 + two bytes ----
        r0 = rise_cyc_b.size();
        hi = hi_w_b.size();
        push_b(8'h82);
        push_b(8'h3C);
        push_b(8'h96);
        step(2);
        wait_idle_b("sa", 600);
        step(3);
        chk("sa_rises", 32'(rise_cyc_b.size() - r0), 32'd16);
        bad = 0;
        for (int i = hi; i < hi_w_b.size(); i++) begin
            if (hi_w_b[i] != 5) bad++;
        end
        chk("sa_high_width", 32'(bad), 32'd0);
        chk("sa_pulses", 32'(hi_w_b.size() - hi), 32'd16);
        bad = 0;
        if (rise_cyc_b.size() >= r0 + 16) begin
            for (int i = 1; i < 16; i++) begin
                if ((i != 8) && (rise_cyc_b[r0 + i] - rise_cyc_b[r0 + i - 1] != 10)) bad++;
            end
        end
        chk("sa_bit_period", 32'(bad), 32'd0);
        chk("sa_no_tx", 32'(tx_cnt_b), 32'd0);

        // ---- header with zero count ----
        r0 = rise_cyc_b.size();
        push_b(8'h80);
        step(2);
        wait_idle_b("h0", 50);
        step(5);
        chk("h0_no_tck", 32'(rise_cyc_b.size() - r0), 32'd0);
        chk("h0_busy", 32'(busy_b), 32'd0);

        chk("tdi_change_while_tck_high", 32'(tdi_viol_a), 32'd0);
        chk("rd_req_while_empty", 32'(rd_empty_a + rd_empty_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
